writeback_queue: RTL

Write-back serializer for the 32-word register file's single write port. Accepts results from the single-cycle ALU path and from long-latency units (multiplier/divider, load unit) through valid/ready handshakes. Holds them in a small in-order FIFO and drains one entry per cycle onto the register file's `rd`/`rdIn`/`rdWrite` inputs. Provides rs/rt forwarding for results that are queued but not yet written.

---
 rtl/writeback_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back FIFO feeding the register file's single
// write port. ALU and long-latency results enter by valid/ready handshake, one
// entry drains per cycle, and queued-but-unwritten results are forwarded to rs/rt.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     aluValid,
  input  logic [4:0]               aluRd,
  input  logic [31:0]              aluData,
  output logic                     aluReady,
  input  logic                     lngValid,
  input  logic [4:0]               lngRd,
  input  logic [31:0]              lngData,
  output logic                     lngReady,
  output logic [4:0]               rd,
  output logic [31:0]              rdIn,
  output logic                     rdWrite,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  output logic                     rsHit,
  output logic                     rtHit,
  output logic [31:0]              rsFwd,
  output logic [31:0]              rtFwd,
  output logic [$clog2(DEPTH):0]   pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head, tail, lngPtr;
  logic [CW-1:0]   count, free;
  logic            notEmpty, aluStore, lngStore;

  // Space accounting: the head slot popped this cycle is reusable right away,
  // and the ALU claims space before the long-latency source.
  always_comb begin
    notEmpty = (count != '0);
    free     = CW'(DEPTH) - count + CW'(notEmpty);
    aluReady = (free >= CW'(1));
    lngReady = aluValid ? (free >= CW'(2)) : (free >= CW'(1));
    // $zero destinations complete the handshake but are never stored
    aluStore = aluValid && aluReady && (aluRd != 5'd0);
    lngStore = lngValid && lngReady && (lngRd != 5'd0);
    // long entry lands behind the ALU entry only if the ALU one was stored
    lngPtr   = tail + PW'(aluStore);
  end

  // Drain port: head entry goes straight to the register file whenever present
  always_comb begin
    rdWrite = notEmpty;
    rd      = notEmpty ? mem[head].rd   : 5'd0;
    rdIn    = notEmpty ? mem[head].data : 32'd0;
    pending = count;
  end

  // Forwarding: scan oldest to youngest so the youngest match wins; the head
  // is included since the file only captures it at the end of this cycle.
  always_comb begin
    logic [PW-1:0] idx;
    idx   = head;
    rsHit = 1'b0;
    rtHit = 1'b0;
    rsFwd = 32'd0;
    rtFwd = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (rs != 5'd0 && mem[idx].rd == rs) begin
          rsHit = 1'b1;
          rsFwd = mem[idx].data;
        end
        if (rt != 5'd0 && mem[idx].rd == rt) begin
          rtHit = 1'b1;
          rtFwd = mem[idx].data;
        end
      end
    end
  end

  // Pointer and occupancy update; reset discards everything still queued
  always_ff @(posedge clock) begin
    if (!resetN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (notEmpty) head <= head + PW'(1);
      tail  <= tail + PW'(aluStore) + PW'(lngStore);
      count <= count - CW'(notEmpty) + CW'(aluStore) + CW'(lngStore);
    end
  end

  // Entry storage; contents are qualified by count so they need no reset
  always_ff @(posedge clock) begin
    if (aluStore) mem[tail]   <= '{rd: aluRd, data: aluData};
    if (lngStore) mem[lngPtr] <= '{rd: lngRd, data: lngData};
  end
endmodule
